dmem_bridge: RTL and testbench
==============================

// Module: dmem_bridge
// PURPOSE
//   Data-memory bridge directly downstream of the pipelined MIPS core's MEM stage.
//   Converts the core's single-cycle data port into a req/gnt/rvalid handshake toward a variable-latency data RAM.
//   Stalls the core while an access is outstanding.
//   Flags protocol errors: timeout, misalignment, simultaneous read+write.
// PARAMETERS
//   DATA_W     32   data bus width
//   ADDR_W     32   byte address width
//   TIMEOUT    64   max cycles in REQ+WAIT before abort (>=2)
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous, active-high reset
//   memReadM     in   1       core MEM stage issues load (lw)
//   memWriteM    in   1       core MEM stage issues store (sw)
//   addrM        in   ADDR_W  byte address from ALU result
//   wdataM       in   DATA_W  store data
//   rdataM       out  DATA_W  load data to core; valid in DONE, held afterwards
//   stallM       out  1       freeze core pipeline (PC, F/D, D/E, E/M registers)
//   errM         out  1       sticky error flag, cleared only by rst
//   mem_req      out  1       request to RAM
//   mem_we       out  1       1=write, 0=read; stable while mem_req
//   mem_addr     out  ADDR_W  captured address; stable while mem_req
//   mem_wdata    out  DATA_W  captured store data; stable while mem_req
//   mem_gnt      in   1       RAM accepts request (valid only with mem_req)
//   mem_rvalid   in   1       read data valid
//   mem_rdata    in   DATA_W  read data
// BEHAVIOUR
//   Reset (async, immediate):
//     state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdataM=0, errM=0.
//     stallM=0 unless an access is presented. Reset mid-transaction drops mem_req at once.
//   FSM states: IDLE, REQ, WAIT, DONE.
//   stallM (combinational) = (IDLE & (memReadM|memWriteM)) | REQ | WAIT. stallM=0 in DONE.
//   IDLE: on access, capture addrM/wdataM.
//     - we = memWriteM (write wins if both set; both set also sets errM).
//     - addrM[1:0]!=0: no request issued, errM<=1, rdataM<=0, ->DONE.
//     - otherwise ->REQ.
//   REQ: mem_req=1.
//     - gnt & we: ->DONE (posted write).
//     - gnt & read & rvalid same cycle: capture rdata, ->DONE.
//     - gnt & read: ->WAIT.
//     - no gnt: stay in REQ.
//   WAIT: mem_req=0; on rvalid capture mem_rdata into rdataM, ->DONE.
//   DONE: one cycle; core advances past the access; ->IDLE unconditionally.
//     The access presented during DONE is the completed one and is never reissued.
//   Timeout: counter clears on entry to REQ and counts cycles in REQ/WAIT.
//     Reaching TIMEOUT: errM<=1, rdataM<=0, ->DONE, mem_req drops.
//   mem_rvalid/mem_gnt outside the expected state are ignored (including stale rvalid after reset or timeout).
//   Latency (gnt in 1st REQ cycle, rvalid next cycle): load stalls 3 cycles, store stalls 2.
//   No access: zero stall, zero added latency.
// STRUCTURE
//   Package dmem_bridge_pkg: state encoding (2-bit localparams); ERR_RDATA=0; timeout counter width = clog2(TIMEOUT+1).
//   One sub-module: dmem_timeout_cnt (clear, enable, expired).
//   FSM and capture registers stay in this module.
// TESTING
//   1. Store 0x1234_5678 @0x10, gnt in 1st REQ cycle -> mem_we=1, mem_addr=0x10 while req; stallM high 2 cycles; errM=0.
//   2. Load @0x20, gnt immediate, rvalid 1 cycle later with 0xCAFE_F00D -> stallM high 3 cycles; rdataM=0xCAFE_F00D in DONE.
//   3. Load, gnt withheld 5 cycles, rvalid same cycle as gnt -> single REQ->DONE; addr/we stable throughout req.
//   4. Load @0x22 -> no mem_req ever; errM=1; rdataM=0; stallM 1 cycle.
//   5. No rvalid after gnt with TIMEOUT=8 -> DONE after 8 cycles; errM=1; later stray rvalid ignored.
//   6. rst asserted in WAIT -> mem_req/stallM/errM drop same cycle; stale rvalid after release leaves rdataM=0.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared encodings and sizing helpers for the MEM-stage data bridge.
package dmem_bridge_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Load data returned to the core when an access is aborted.
    localparam int ERR_RDATA = 0;

    function automatic int tmo_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction
endpackage

// File: rtl/dmem_timeout_cnt.sv
// Watchdog for an outstanding RAM access: expires on the TIMEOUT-th enabled cycle.
module dmem_timeout_cnt
    import dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = tmo_cnt_w(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/dmem_bridge.sv
// Turns the core's single-cycle data port into a req/gnt/rvalid RAM handshake,
// stalling the pipeline while the access is outstanding.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memReadM,
    input  logic              memWriteM,
    input  logic [ADDR_W-1:0] addrM,
    input  logic [DATA_W-1:0] wdataM,
    output logic [DATA_W-1:0] rdataM,
    output logic              stallM,
    output logic              errM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);
    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              access, tmo_clr, tmo_en, tmo_expired;

    assign access = memReadM | memWriteM;
    assign tmo_en = (state_q == ST_REQ) || (state_q == ST_WAIT);

    dmem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_clr = 1'b0;
        case (state_q)
            ST_IDLE: if (access) begin
                addr_d  = addrM;
                wdata_d = wdataM;
                we_d    = memWriteM;
                if (memReadM && memWriteM) err_d = 1'b1;
                if (addrM[1:0] != 2'b00) begin
                    err_d   = 1'b1;
                    rdata_d = DATA_W'(ERR_RDATA);
                    state_d = ST_DONE;
                end else begin
                    tmo_clr = 1'b1;
                    state_d = ST_REQ;
                end
            end
            // A real completion in the expiry cycle wins over the abort.
            ST_REQ: begin
                if (mem_gnt && we_q) begin
                    state_d = ST_DONE;
                end else if (mem_gnt && mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = ST_DONE;
                end else if (mem_gnt) begin
                    state_d = ST_WAIT;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    rdata_d = DATA_W'(ERR_RDATA);
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = ST_DONE;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    rdata_d = DATA_W'(ERR_RDATA);
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign stallM    = ((state_q == ST_IDLE) && access) || tmo_en;
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdataM    = rdata_q;
    assign errM      = err_q;
endmodule

// File: tb/tb_dmem_bridge.sv
// Directed vector bench for dmem_bridge (TIMEOUT=8).
module tb_dmem_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        memReadM, memWriteM;
    logic [31:0] addrM, wdataM, rdataM;
    logic        stallM, errM, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    dmem_bridge #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .memReadM(memReadM), .memWriteM(memWriteM), .addrM(addrM), .wdataM(wdataM),
        .rdataM(rdataM), .stallM(stallM), .errM(errM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wd;
        logic        gnt, rv;
        logic [31:0] rdat;
        logic        stall, req, we;
        logic [31:0] maddr, mwd;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic g, input logic rv, input logic [31:0] rdat);
        memReadM = rd; memWriteM = wr; addrM = a; wdataM = wd;
        mem_gnt = g; mem_rvalid = rv; mem_rdata = rdat;
    endtask

    initial begin
        string tag;
        //                rd wr addr       wdata         gnt rv rdata         stall req we maddr     mwdata        err rdataM
        tbl[0]  = '{1'b0,1'b1,32'h10,32'h1234_5678,1'b0,1'b0,32'h0,          1'b1,1'b0,1'b0,32'h0, 32'h0,          1'b0,32'h0};
        tbl[1]  = '{1'b0,1'b1,32'h10,32'h1234_5678,1'b1,1'b0,32'h0,          1'b1,1'b1,1'b1,32'h10,32'h1234_5678,1'b0,32'h0};
        tbl[2]  = '{1'b0,1'b1,32'h10,32'h1234_5678,1'b0,1'b0,32'h0,          1'b0,1'b0,1'b1,32'h10,32'h1234_5678,1'b0,32'h0};
        tbl[3]  = '{1'b0,1'b0,32'h0, 32'h0,        1'b0,1'b0,32'h0,          1'b0,1'b0,1'b1,32'h10,32'h1234_5678,1'b0,32'h0};
        tbl[4]  = '{1'b1,1'b0,32'h20,32'h0,        1'b0,1'b0,32'h0,          1'b1,1'b0,1'b1,32'h10,32'h1234_5678,1'b0,32'h0};
        tbl[5]  = '{1'b1,1'b0,32'h20,32'h0,        1'b1,1'b0,32'h0,          1'b1,1'b1,1'b0,32'h20,32'h0,        1'b0,32'h0};
        tbl[6]  = '{1'b1,1'b0,32'h20,32'h0,        1'b0,1'b1,32'hCAFE_F00D,  1'b1,1'b0,1'b0,32'h20,32'h0,        1'b0,32'h0};
        tbl[7]  = '{1'b1,1'b0,32'h20,32'h0,        1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,32'h20,32'h0,        1'b0,32'hCAFE_F00D};
        tbl[8]  = '{1'b0,1'b0,32'h0, 32'h0,        1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,32'h20,32'h0,        1'b0,32'hCAFE_F00D};
        tbl[9]  = '{1'b1,1'b0,32'h22,32'h0,        1'b0,1'b0,32'h0,          1'b1,1'b0,1'b0,32'h20,32'h0,        1'b0,32'hCAFE_F00D};
        tbl[10] = '{1'b1,1'b0,32'h22,32'h0,        1'b1,1'b0,32'h0,          1'b0,1'b0,1'b0,32'h22,32'h0,        1'b1,32'h0};
        tbl[11] = '{1'b0,1'b0,32'h0, 32'h0,        1'b0,1'b1,32'hDEAD_BEEF,  1'b0,1'b0,1'b0,32'h22,32'h0,        1'b1,32'h0};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("reset_req",   {31'b0, mem_req}, 32'h0);
        chk("reset_stall", {31'b0, stallM},  32'h0);
        chk("reset_err",   {31'b0, errM},    32'h0);
        chk("reset_rdata", rdataM,           32'h0);
        chk("reset_addr",  mem_addr,         32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Store, load and misaligned load, one record per clock.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].gnt, tbl[i].rv, tbl[i].rdat);
            #1;
            tag = $sformatf("vec%0d", i);
            chk({tag, "_stall"}, {31'b0, stallM},  {31'b0, tbl[i].stall});
            chk({tag, "_req"},   {31'b0, mem_req}, {31'b0, tbl[i].req});
            chk({tag, "_we"},    {31'b0, mem_we},  {31'b0, tbl[i].we});
            chk({tag, "_addr"},  mem_addr,         tbl[i].maddr);
            chk({tag, "_wdata"}, mem_wdata,        tbl[i].mwd);
            chk({tag, "_err"},   {31'b0, errM},    {31'b0, tbl[i].err});
            chk({tag, "_rdata"}, rdataM,           tbl[i].rdata);
            tick();
        end

        // Load with grant withheld 5 cycles, rvalid together with gnt.
        rst = 1'b1; tick(); rst = 1'b0;
        drive(1, 0, 32'h44, 0, 0, 0, 0); #1;
        chk("ld_late_idle_stall", {31'b0, stallM}, 32'h1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 32'h44, 0, 0, 0, 0); #1;
            chk("ld_late_req",   {31'b0, mem_req}, 32'h1);
            chk("ld_late_we",    {31'b0, mem_we},  32'h0);
            chk("ld_late_addr",  mem_addr,         32'h44);
            chk("ld_late_stall", {31'b0, stallM},  32'h1);
            tick();
        end
        drive(1, 0, 32'h44, 0, 1, 1, 32'h0BAD_BEEF); #1;
        chk("ld_late_gnt_req",  {31'b0, mem_req}, 32'h1);
        chk("ld_late_gnt_addr", mem_addr,         32'h44);
        tick();
        drive(1, 0, 32'h44, 0, 0, 0, 0); #1;
        chk("ld_late_done_stall", {31'b0, stallM},  32'h0);
        chk("ld_late_done_req",   {31'b0, mem_req}, 32'h0);
        chk("ld_late_done_rdata", rdataM,           32'h0BAD_BEEF);
        chk("ld_late_done_err",   {31'b0, errM},    32'h0);
        tick();

        // Granted load that never returns data: abort after 8 cycles.
        rst = 1'b1; tick(); rst = 1'b0;
        drive(1, 0, 32'h30, 0, 0, 0, 0); #1;
        chk("tmo_idle_stall", {31'b0, stallM}, 32'h1);
        tick();
        drive(1, 0, 32'h30, 0, 1, 0, 0); #1;
        chk("tmo_req", {31'b0, mem_req}, 32'h1);
        tick();
        drive(1, 0, 32'h30, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("tmo_wait_stall", {31'b0, stallM},  32'h1);
            chk("tmo_wait_req",   {31'b0, mem_req}, 32'h0);
            tick();
        end
        #1;
        chk("tmo_done_stall", {31'b0, stallM}, 32'h0);
        chk("tmo_done_err",   {31'b0, errM},   32'h1);
        chk("tmo_done_rdata", rdataM,          32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h5555_5555); #1;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0); #1;
        chk("tmo_stray_rdata", rdataM,          32'h0);
        chk("tmo_stray_stall", {31'b0, stallM}, 32'h0);
        chk("tmo_err_sticky",  {31'b0, errM},   32'h1);
        tick();

        // Reset while waiting for read data.
        drive(1, 0, 32'h40, 0, 0, 0, 0); #1;
        tick();
        drive(1, 0, 32'h40, 0, 1, 0, 0); #1;
        chk("rst_req_phase", {31'b0, mem_req}, 32'h1);
        tick();
        drive(1, 0, 32'h40, 0, 0, 0, 0); #1;
        chk("rst_wait_stall", {31'b0, stallM}, 32'h1);
        rst = 1'b1;
        memReadM = 1'b0;
        #1;
        chk("rst_async_req",   {31'b0, mem_req}, 32'h0);
        chk("rst_async_stall", {31'b0, stallM},  32'h0);
        chk("rst_async_err",   {31'b0, errM},    32'h0);
        chk("rst_async_addr",  mem_addr,         32'h0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 32'h7777_7777); #1;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0); #1;
        chk("rst_stale_rdata", rdataM,           32'h0);
        chk("rst_stale_req",   {31'b0, mem_req}, 32'h0);
        chk("rst_stale_stall", {31'b0, stallM},  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
